apb_master_initiator: RTL and testbench

- Synthesizable APB initiator. Converts a valid/ready request into one APB transfer (SETUP then ACCESS), waits for PREADY, and returns read data and error status on a valid/ready response channel.
- Drives the same PADDR/PSEL/PENABLE/PWRITE/PWDATA bus that the APB slave agent and its monitor BFM observe, so it is the initiator end of that interface.
- The PSEL vector is one-hot, and each slave is addressed by its index into PSEL.

---
 rtl/apb_master_initiator_if.sv | 49 ++++
 rtl/apb_master_initiator.sv | 160 ++++++++++++++++
 tb/tb_apb_master_initiator.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_initiator_if.sv
// Request/response channels plus the APB bus of the APB initiator.
// The master modport is the initiator; the slave modport is its environment
// (request source, response sink and the addressed APB slave).
interface apb_master_initiator_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 32,
    parameter int SEL_WIDTH  = $clog2(NUM_SLAVES)
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_write;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [SEL_WIDTH-1:0]  req_sel;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_slverr;
    logic                  rsp_timeout;

    logic [ADDR_WIDTH-1:0] PADDR;
    logic [NUM_SLAVES-1:0] PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata, req_sel,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        input  rsp_ready,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata, req_sel,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        output rsp_ready,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_master_initiator.sv
// APB initiator: turns one valid/ready request into a SETUP+ACCESS transfer
// and returns read data / error status on a valid/ready response channel.
// Optional build macro APB_MASTER_TIMEOUT_EN bounds the ACCESS wait to
// TIMEOUT_CYCLES consecutive PREADY-low cycles and flags rsp_timeout.
module apb_master_initiator #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 32,
    parameter int SEL_WIDTH      = $clog2(NUM_SLAVES),
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic PCLK,
    input logic PRESET,
    apb_master_initiator_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [31:0] NUM_SLAVES_U = 32'(NUM_SLAVES);

    state_t                state_reg, state_next;
    logic [SEL_WIDTH-1:0]  sel_reg, sel_next;
    logic [ADDR_WIDTH-1:0] paddr_reg, paddr_next;
    logic                  pwrite_reg, pwrite_next;
    logic [DATA_WIDTH-1:0] pwdata_reg, pwdata_next;
    logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
    logic                  slverr_reg, slverr_next;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic                  timeout_reg, timeout_next;
`endif

    logic                  sel_ok;
    logic                  bus_active;
    logic [NUM_SLAVES-1:0] psel_dec;

    // Out-of-range indices are answered locally with an error, never on the bus.
    assign sel_ok     = (32'(bus.req_sel) < NUM_SLAVES_U);
    assign bus_active = (state_reg == SETUP) || (state_reg == ACCESS);

    // One-hot decode of the captured slave index.
    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_psel
            assign psel_dec[gi] = (sel_reg == SEL_WIDTH'(gi));
        end
    endgenerate

    // Next-state and captured-field logic; everything holds by default.
    always_comb begin
        state_next  = state_reg;
        sel_next    = sel_reg;
        paddr_next  = paddr_reg;
        pwrite_next = pwrite_reg;
        pwdata_next = pwdata_reg;
        rdata_next  = rdata_reg;
        slverr_next = slverr_reg;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_next     = cnt_reg;
        timeout_next = timeout_reg;
`endif
        unique case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    if (sel_ok) begin
                        state_next  = SETUP;
                        sel_next    = bus.req_sel;
                        paddr_next  = bus.req_addr;
                        pwrite_next = bus.req_write;
                        pwdata_next = bus.req_write ? bus.req_wdata : '0;
                    end else begin
                        state_next  = RESP;
                        rdata_next  = '0;
                        slverr_next = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                        timeout_next = 1'b0;
`endif
                    end
                end
            end
            SETUP: begin
                state_next = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                cnt_next = '0;
`endif
            end
            ACCESS: begin
                // PREADY wins over the timeout on the final counted cycle.
                if (bus.PREADY) begin
                    state_next  = RESP;
                    slverr_next = bus.PSLVERR;
                    rdata_next  = (!pwrite_reg && !bus.PSLVERR) ? bus.PRDATA : '0;
`ifdef APB_MASTER_TIMEOUT_EN
                    timeout_next = 1'b0;
                end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_next   = RESP;
                    slverr_next  = 1'b1;
                    rdata_next   = '0;
                    timeout_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
`endif
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and captured-field registers; reset abandons any transfer.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_reg  <= IDLE;
            sel_reg    <= '0;
            paddr_reg  <= '0;
            pwrite_reg <= 1'b0;
            pwdata_reg <= '0;
            rdata_reg  <= '0;
            slverr_reg <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            sel_reg    <= sel_next;
            paddr_reg  <= paddr_next;
            pwrite_reg <= pwrite_next;
            pwdata_reg <= pwdata_next;
            rdata_reg  <= rdata_next;
            slverr_reg <= slverr_next;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
`endif
        end
    end

    // req_ready is masked while reset is held so nothing looks accepted then.
    assign bus.req_ready  = (state_reg == IDLE) && !PRESET;
    assign bus.rsp_valid  = (state_reg == RESP);
    assign bus.rsp_rdata  = rdata_reg;
    assign bus.rsp_slverr = slverr_reg;
`ifdef APB_MASTER_TIMEOUT_EN
    assign bus.rsp_timeout = timeout_reg;
`else
    // No bound is built; the parameter only matters with the timeout enabled.
    assign bus.rsp_timeout = (TIMEOUT_CYCLES < 0);
`endif

    assign bus.PADDR   = paddr_reg;
    assign bus.PWRITE  = pwrite_reg;
    assign bus.PWDATA  = pwdata_reg;
    assign bus.PENABLE = (state_reg == ACCESS);
    assign bus.PSEL    = bus_active ? psel_dec : '0;
endmodule

// File: tb/tb_apb_master_initiator.sv
// Randomised self-checking bench for apb_master_initiator. Expected results
// come from a transaction-level model: one request in, one response out,
// latency 3 + wait states (1 for an out-of-range slave index).
module tb_apb_master_initiator;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 32;
    localparam int SW = 6;   // wide enough to express illegal indices >= NS
    localparam int TO = 4;

    logic PCLK = 1'b0;
    logic PRESET;
    always #5 PCLK = ~PCLK;

    apb_master_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .SEL_WIDTH(SW)) bus ();

    apb_master_initiator #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .SEL_WIDTH(SW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK(PCLK),
        .PRESET(PRESET),
        .bus(bus)
    );

    int vectors = 0;
    int errors  = 0;

    // Model state: bus fields keep their last driven value while idle.
    logic [AW-1:0] last_paddr  = '0;
    logic          last_pwrite = 1'b0;
    logic [DW-1:0] last_pwdata = '0;

    typedef struct {
        logic          acc_ready;
        logic [NS-1:0] s_psel;
        logic          s_pen;
        logic [AW-1:0] s_paddr;
        logic          s_pwrite;
        logic [DW-1:0] s_pwdata;
        logic          acc_ok;
        int            lat;
        logic [DW-1:0] rdata;
        logic          slverr;
        logic          tmo;
        logic          hold_ok;
        logic          idle_ready;
        logic          idle_rsp;
    } obs_t;

    // Transaction-level expectation for one request.
    task automatic model_xfer(input logic wr, input logic [SW-1:0] sel, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input int waits, input logic [DW-1:0] prdata,
                              input logic perr, output obs_t e);
        logic [NS-1:0] one;
        one = 1;
        e.acc_ready = 1'b1; e.s_pen = 1'b0; e.acc_ok = 1'b1; e.hold_ok = 1'b1;
        e.idle_ready = 1'b1; e.idle_rsp = 1'b0; e.tmo = 1'b0;
        if (int'(sel) >= NS) begin
            e.s_psel = '0; e.lat = 1; e.slverr = 1'b1; e.rdata = '0;
        end else begin
            last_paddr  = addr;
            last_pwrite = wr;
            last_pwdata = wr ? wdata : '0;
            e.s_psel = one << sel;
            e.lat    = 3 + waits;
            e.slverr = perr;
            e.rdata  = (wr || perr) ? '0 : prdata;
`ifdef APB_MASTER_TIMEOUT_EN
            if (waits >= TO) begin
                e.lat = 2 + TO; e.slverr = 1'b1; e.tmo = 1'b1; e.rdata = '0;
            end
`endif
        end
        e.s_paddr = last_paddr; e.s_pwrite = last_pwrite; e.s_pwdata = last_pwdata;
    endtask

    // Plays requester, APB slave and response sink for one transfer.
    // Called at a falling edge; returns at the falling edge after the response handshake.
    task automatic drive_xfer(input logic wr, input logic [SW-1:0] sel, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input int waits, input logic [DW-1:0] prdata,
                              input logic perr, input int hold, input logic keep_valid, output obs_t o);
        o.acc_ready = bus.req_ready;
        o.s_psel = '0; o.s_pen = 1'b0; o.s_paddr = '0; o.s_pwrite = 1'b0; o.s_pwdata = '0;
        o.acc_ok = 1'b1; o.lat = -1; o.rdata = '0; o.slverr = 1'b0; o.tmo = 1'b0;
        o.hold_ok = 1'b1; o.idle_ready = 1'b0; o.idle_rsp = 1'b1;
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_sel = sel;
        bus.req_addr = addr; bus.req_wdata = wdata;
        bus.PREADY = 1'b0; bus.rsp_ready = 1'b0;
        for (int c = 1; c <= 64; c++) begin
            @(negedge PCLK);
            if (c == 1) begin
                o.s_psel = bus.PSEL; o.s_pen = bus.PENABLE; o.s_paddr = bus.PADDR;
                o.s_pwrite = bus.PWRITE; o.s_pwdata = bus.PWDATA;
                if (!keep_valid) bus.req_valid = 1'b0;
            end
            if (bus.rsp_valid === 1'b1) begin
                o.lat = c; o.rdata = bus.rsp_rdata; o.slverr = bus.rsp_slverr; o.tmo = bus.rsp_timeout;
                break;
            end
            if (c >= 2) begin
                if (bus.PENABLE !== 1'b1 || bus.PSEL !== o.s_psel || bus.PADDR !== o.s_paddr ||
                    bus.PWRITE !== o.s_pwrite || bus.PWDATA !== o.s_pwdata)
                    o.acc_ok = 1'b0;
            end
            // Slave answers on the (waits+1)-th ACCESS cycle; junk is offered before that.
            bus.PREADY  = (c == 2 + waits);
            bus.PRDATA  = bus.PREADY ? prdata : DW'($urandom());
            bus.PSLVERR = bus.PREADY ? perr : 1'($urandom());
        end
        bus.PREADY = 1'b0;
        if (o.lat > 0) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge PCLK);
                if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== o.rdata || bus.rsp_slverr !== o.slverr ||
                    bus.rsp_timeout !== o.tmo || bus.req_ready !== 1'b0 || bus.PSEL !== '0)
                    o.hold_ok = 1'b0;
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge PCLK);
        o.idle_ready = bus.req_ready;
        o.idle_rsp   = bus.rsp_valid;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        $display("xfer wr=%0b sel=%0d addr=%h waits=%0d lat=%0d rdata=%h slverr=%0b tmo=%0b",
                 wr, sel, addr, waits, o.lat, o.rdata, o.slverr, o.tmo);
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_sel = '0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.rsp_ready = 1'b0; bus.PRDATA = '0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
        PRESET = 1'b1;
        repeat (2) @(negedge PCLK);
        vectors++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", bus.req_ready); end
        vectors++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
        vectors++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== '0) begin errors++; $display("FAIL reset_psel_pen got %h/%b exp 0", bus.PSEL, bus.PENABLE); end
        vectors++; if ({bus.PADDR, bus.PWDATA} !== '0) begin errors++; $display("FAIL reset_paddr_pwdata got %h/%h exp 0", bus.PADDR, bus.PWDATA); end
        vectors++; if ({bus.rsp_rdata, bus.rsp_slverr, bus.rsp_timeout} !== '0) begin errors++; $display("FAIL reset_rsp_fields got %h exp 0", bus.rsp_rdata); end
        PRESET = 1'b0;
        last_paddr = '0; last_pwrite = 1'b0; last_pwdata = '0;
        @(negedge PCLK);
        vectors++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL first_idle_req_ready got %b exp 1", bus.req_ready); end
    endtask

    task automatic test_write();
        obs_t o, e;
        model_xfer(1'b1, 6'd3, 32'h1000, 32'hDEADBEEF, 0, 32'h0, 1'b0, e);
        drive_xfer(1'b1, 6'd3, 32'h1000, 32'hDEADBEEF, 0, 32'hCAFE0000, 1'b0, 0, 1'b0, o);
        vectors++; if (o.s_psel !== e.s_psel) begin errors++; $display("FAIL wr_setup_psel got %h exp %h", o.s_psel, e.s_psel); end
        vectors++; if (o.s_pen !== 1'b0) begin errors++; $display("FAIL wr_setup_penable got %b exp 0", o.s_pen); end
        vectors++; if (o.s_pwdata !== e.s_pwdata) begin errors++; $display("FAIL wr_pwdata got %h exp %h", o.s_pwdata, e.s_pwdata); end
        vectors++; if (o.acc_ok !== 1'b1) begin errors++; $display("FAIL wr_access_penable got %b exp 1", o.acc_ok); end
        vectors++; if (o.lat !== e.lat) begin errors++; $display("FAIL wr_latency got %0d exp %0d", o.lat, e.lat); end
        vectors++; if ({o.slverr, o.rdata} !== {e.slverr, e.rdata}) begin errors++; $display("FAIL wr_rsp got %b/%h exp %b/%h", o.slverr, o.rdata, e.slverr, e.rdata); end
    endtask

    task automatic test_wait_read();
        obs_t o, e;
        model_xfer(1'b0, 6'd0, 32'h20, 32'h0, 2, 32'h12345678, 1'b0, e);
        drive_xfer(1'b0, 6'd0, 32'h20, 32'h55AA55AA, 2, 32'h12345678, 1'b0, 0, 1'b0, o);
        vectors++; if (o.s_paddr !== e.s_paddr || o.s_psel !== e.s_psel) begin errors++; $display("FAIL rd_setup_addr got %h/%h exp %h/%h", o.s_paddr, o.s_psel, e.s_paddr, e.s_psel); end
        vectors++; if (o.s_pwdata !== e.s_pwdata) begin errors++; $display("FAIL rd_pwdata got %h exp %h", o.s_pwdata, e.s_pwdata); end
        vectors++; if (o.acc_ok !== 1'b1) begin errors++; $display("FAIL rd_access_stable got %b exp 1", o.acc_ok); end
        vectors++; if (o.lat !== e.lat) begin errors++; $display("FAIL rd_latency got %0d exp %0d", o.lat, e.lat); end
        vectors++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL rd_rdata got %h exp %h", o.rdata, e.rdata); end
    endtask

    task automatic test_errors();
        obs_t o, e;
        model_xfer(1'b0, 6'd7, 32'h44, 32'h0, 1, 32'h0BADF00D, 1'b1, e);
        drive_xfer(1'b0, 6'd7, 32'h44, 32'h0, 1, 32'h0BADF00D, 1'b1, 0, 1'b0, o);
        vectors++; if ({o.slverr, o.rdata} !== {e.slverr, e.rdata}) begin errors++; $display("FAIL pslverr_rsp got %b/%h exp %b/%h", o.slverr, o.rdata, e.slverr, e.rdata); end
        model_xfer(1'b1, 6'd40, 32'h9999, 32'h1111, 0, 32'h0, 1'b0, e);
        drive_xfer(1'b1, 6'd40, 32'h9999, 32'h1111, 0, 32'h0, 1'b0, 1, 1'b0, o);
        vectors++; if ({o.s_psel, o.s_pen} !== '0) begin errors++; $display("FAIL badsel_no_psel got %h/%b exp 0", o.s_psel, o.s_pen); end
        vectors++; if (o.s_paddr !== e.s_paddr) begin errors++; $display("FAIL badsel_paddr_held got %h exp %h", o.s_paddr, e.s_paddr); end
        vectors++; if (o.lat !== e.lat) begin errors++; $display("FAIL badsel_latency got %0d exp %0d", o.lat, e.lat); end
        vectors++; if ({o.slverr, o.rdata} !== {e.slverr, e.rdata}) begin errors++; $display("FAIL badsel_rsp got %b/%h exp %b/%h", o.slverr, o.rdata, e.slverr, e.rdata); end
    endtask

    task automatic test_backpressure();
        obs_t o, e;
        model_xfer(1'b0, 6'd12, 32'hA0, 32'h0, 0, 32'h600DD00D, 1'b0, e);
        drive_xfer(1'b0, 6'd12, 32'hA0, 32'h0, 0, 32'h600DD00D, 1'b0, 5, 1'b1, o);
        vectors++; if (o.hold_ok !== 1'b1) begin errors++; $display("FAIL bp_hold_stable got %b exp 1", o.hold_ok); end
        vectors++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL bp_rdata got %h exp %h", o.rdata, e.rdata); end
        vectors++; if ({o.idle_ready, o.idle_rsp} !== 2'b10) begin errors++; $display("FAIL bp_release got %b%b exp 10", o.idle_ready, o.idle_rsp); end
        model_xfer(1'b1, 6'd13, 32'hB0, 32'h77, 0, 32'h0, 1'b0, e);
        drive_xfer(1'b1, 6'd13, 32'hB0, 32'h77, 0, 32'h0, 1'b0, 0, 1'b0, o);
        vectors++; if (o.acc_ready !== 1'b1 || o.s_paddr !== e.s_paddr) begin errors++; $display("FAIL bp_next_accept got %b/%h exp 1/%h", o.acc_ready, o.s_paddr, e.s_paddr); end
    endtask

    task automatic test_random_back_to_back();
        obs_t o, e;
        for (int i = 0; i < 40; i++) begin
            logic wr, perr;
            logic [SW-1:0] sel;
            logic [AW-1:0] addr;
            logic [DW-1:0] wdata, prdata;
            int waits, hold;
            wr = 1'($urandom_range(0, 1));
            sel = ($urandom_range(0, 7) == 0) ? SW'($urandom_range(32, 63)) : SW'($urandom_range(0, 31));
            addr = $urandom(); wdata = $urandom(); prdata = $urandom();
            waits = $urandom_range(0, 3); hold = $urandom_range(0, 2);
            perr = ($urandom_range(0, 3) == 0);
            model_xfer(wr, sel, addr, wdata, waits, prdata, perr, e);
            drive_xfer(wr, sel, addr, wdata, waits, prdata, perr, hold, 1'b0, o);
            vectors++; if (o.acc_ready !== 1'b1) begin errors++; $display("FAIL rnd%0d accept got %b exp 1", i, o.acc_ready); end
            vectors++; if (o.s_psel !== e.s_psel) begin errors++; $display("FAIL rnd%0d psel got %h exp %h", i, o.s_psel, e.s_psel); end
            vectors++; if (o.s_pen !== e.s_pen) begin errors++; $display("FAIL rnd%0d setup_pen got %b exp %b", i, o.s_pen, e.s_pen); end
            vectors++; if (o.s_paddr !== e.s_paddr) begin errors++; $display("FAIL rnd%0d paddr got %h exp %h", i, o.s_paddr, e.s_paddr); end
            vectors++; if (o.s_pwrite !== e.s_pwrite) begin errors++; $display("FAIL rnd%0d pwrite got %b exp %b", i, o.s_pwrite, e.s_pwrite); end
            vectors++; if (o.s_pwdata !== e.s_pwdata) begin errors++; $display("FAIL rnd%0d pwdata got %h exp %h", i, o.s_pwdata, e.s_pwdata); end
            vectors++; if (o.acc_ok !== e.acc_ok) begin errors++; $display("FAIL rnd%0d access_stable got %b exp %b", i, o.acc_ok, e.acc_ok); end
            vectors++; if (o.lat !== e.lat) begin errors++; $display("FAIL rnd%0d latency got %0d exp %0d", i, o.lat, e.lat); end
            vectors++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL rnd%0d rdata got %h exp %h", i, o.rdata, e.rdata); end
            vectors++; if (o.slverr !== e.slverr) begin errors++; $display("FAIL rnd%0d slverr got %b exp %b", i, o.slverr, e.slverr); end
            vectors++; if (o.tmo !== e.tmo) begin errors++; $display("FAIL rnd%0d timeout got %b exp %b", i, o.tmo, e.tmo); end
            vectors++; if (o.hold_ok !== e.hold_ok) begin errors++; $display("FAIL rnd%0d hold got %b exp %b", i, o.hold_ok, e.hold_ok); end
            vectors++; if ({o.idle_ready, o.idle_rsp} !== {e.idle_ready, e.idle_rsp}) begin errors++; $display("FAIL rnd%0d idle got %b%b exp %b%b", i, o.idle_ready, o.idle_rsp, e.idle_ready, e.idle_rsp); end
        end
    endtask

    task automatic test_reset_mid();
        logic quiet;
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_sel = 6'd5;
        bus.req_addr = 32'h5000; bus.req_wdata = 32'h12; bus.PREADY = 1'b0;
        @(negedge PCLK);
        bus.req_valid = 1'b0;
        @(negedge PCLK);
        vectors++; if (bus.PENABLE !== 1'b1) begin errors++; $display("FAIL rstmid_in_access got %b exp 1", bus.PENABLE); end
        PRESET = 1'b1;
        @(negedge PCLK);
        vectors++; if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== '0) begin errors++; $display("FAIL rstmid_bus_drop got %h/%b/%b exp 0", bus.PSEL, bus.PENABLE, bus.rsp_valid); end
        vectors++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rstmid_req_ready got %b exp 0", bus.req_ready); end
        PRESET = 1'b0;
        last_paddr = '0; last_pwrite = 1'b0; last_pwdata = '0;
        quiet = 1'b1;
        repeat (3) begin
            @(negedge PCLK);
            if (bus.rsp_valid !== 1'b0 || bus.PSEL !== '0) quiet = 1'b0;
        end
        vectors++; if (quiet !== 1'b1) begin errors++; $display("FAIL rstmid_no_response got %b exp 1", quiet); end
        vectors++; if (bus.req_ready !== 1'b1 || bus.PADDR !== last_paddr) begin errors++; $display("FAIL rstmid_idle got %b/%h exp 1/%h", bus.req_ready, bus.PADDR, last_paddr); end
    endtask

    task automatic test_timeout();
        obs_t o, e;
        logic [DW-1:0] pd;
        // Slave answers on the last cycle the timeout would count.
        pd = $urandom();
        model_xfer(1'b0, 6'd9, 32'hC0, 32'h0, TO - 1, pd, 1'b0, e);
        drive_xfer(1'b0, 6'd9, 32'hC0, 32'h0, TO - 1, pd, 1'b0, 0, 1'b0, o);
        vectors++; if (o.lat !== e.lat || o.tmo !== e.tmo) begin errors++; $display("FAIL last_cycle_ready got %0d/%b exp %0d/%b", o.lat, o.tmo, e.lat, e.tmo); end
        vectors++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL last_cycle_rdata got %h exp %h", o.rdata, e.rdata); end
`ifdef APB_MASTER_TIMEOUT_EN
        model_xfer(1'b0, 6'd2, 32'hD0, 32'h0, 1000, 32'h0, 1'b0, e);
        drive_xfer(1'b0, 6'd2, 32'hD0, 32'h0, 1000, 32'hFFFF0000, 1'b0, 1, 1'b0, o);
        vectors++; if (o.lat !== e.lat) begin errors++; $display("FAIL timeout_latency got %0d exp %0d", o.lat, e.lat); end
        vectors++; if ({o.tmo, o.slverr, o.rdata} !== {e.tmo, e.slverr, e.rdata}) begin errors++; $display("FAIL timeout_rsp got %b/%b/%h exp %b/%b/%h", o.tmo, o.slverr, o.rdata, e.tmo, e.slverr, e.rdata); end
        vectors++; if (o.acc_ok !== 1'b1 || o.hold_ok !== 1'b1) begin errors++; $display("FAIL timeout_bus got %b/%b exp 1/1", o.acc_ok, o.hold_ok); end
`else
        begin
            logic waiting;
            waiting = 1'b1;
            bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_sel = 6'd2; bus.req_addr = 32'hD0;
            bus.PREADY = 1'b0;
            @(negedge PCLK);
            bus.req_valid = 1'b0;
            repeat (20) begin
                @(negedge PCLK);
                if (bus.PENABLE !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_timeout !== 1'b0) waiting = 1'b0;
            end
            vectors++; if (waiting !== 1'b1) begin errors++; $display("FAIL unbounded_wait got %b exp 1", waiting); end
            PRESET = 1'b1;
            @(negedge PCLK);
            PRESET = 1'b0;
            last_paddr = '0; last_pwrite = 1'b0; last_pwdata = '0;
            @(negedge PCLK);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_write();
        test_wait_read();
        test_errors();
        test_backpressure();
        test_random_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end
endmodule
